fdiv_iter: RTL

- Multi-cycle single-precision divider: d = x / y.
- Computes the divisor reciprocal by Newton-Raphson from an 8-bit seed table, multiplies by the dividend, then applies one remainder correction and round-to-nearest-even.
- Sits beside the pipelined reciprocal unit in the FPU and serves the core's fdiv instruction.
- Uses a valid/ready handshake on both input and output; one operation is in flight at a time.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fdiv_iter_if.sv | 24 ++
 rtl/fdiv_seed_rom.sv | 19 +
 rtl/fdiv_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, divider FSM states, special encodings
// and the reciprocal seed table used by both reciprocal and divide units.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int SEED_W = 8;

    localparam logic [30:0] INF_MAG  = {8'hFF, 23'h0};
    localparam logic [30:0] ZERO_MAG = 31'h0;

    typedef enum logic [3:0] {
        IDLE, SEED, IT1A, IT1B, IT2A, IT2B, MUL, FIX, RND, DONE
    } state_t;

    // round(2^(sb+1) / (1 + idx/2^sb)) - 2^sb; idx 0 would need one more bit, so it clamps
    function automatic int seed_of(input int idx, input int sb);
        int den;
        int num;
        int r;
        den = (1 << sb) + idx;
        num = 1 << (2 * sb + 1);
        r   = (2 * num + den) / (2 * den) - (1 << sb);
        if (r > (1 << sb) - 1)
            r = (1 << sb) - 1;
        return r;
    endfunction

endpackage

// File: rtl/fdiv_iter_if.sv
// Operand/result handshake bundle for the iterative divider.
interface fdiv_iter_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, d, overflow, underflow
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, d, overflow, underflow
    );

endinterface

// File: rtl/fdiv_seed_rom.sv
// Reciprocal seed lookup: top SEED_BITS of the divisor mantissa -> seed fraction.
// Purely combinational; contents are elaboration-time constants.
module fdiv_seed_rom #(
    parameter int SEED_BITS = fpu_pkg::SEED_W
) (
    input  logic [SEED_BITS-1:0] idx,
    output logic [SEED_BITS-1:0] seed
);
    import fpu_pkg::*;

    logic [SEED_BITS-1:0] seed_tab [2**SEED_BITS];

    for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_tab
        assign seed_tab[i] = SEED_BITS'(seed_of(i, SEED_BITS));
    end

    assign seed = seed_tab[idx];

endmodule

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider (Newton-Raphson reciprocal, remainder fix-up, RNE).
// Fixed latency 2*NEWTON_ITERS+4 cycles to out_valid; result held in DONE until out_ready.
module fdiv_iter #(
    parameter int SEED_BITS    = 8,
    parameter int NEWTON_ITERS = 2
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_iter_if.slave  io
);
    import fpu_pkg::*;

    state_t               state;
    logic [31:0]          x_r;
    logic [31:0]          y_r;
    logic [31:0]          xk;
    logic [31:0]          b_r;
    logic [25:0]          q_r;
    logic                 sticky;
    logic                 lt_r;
    logic [2:0]           it_cnt;
    logic [SEED_BITS-1:0] seed;

    logic [23:0]          xm;
    logic [23:0]          ym;
    logic [EXP_W-1:0]     ex;
    logic [EXP_W-1:0]     ey;
    logic                 sign_d;

    assign xm     = {1'b1, x_r[MAN_W-1:0]};
    assign ym     = {1'b1, y_r[MAN_W-1:0]};
    assign ex     = x_r[MAN_W +: EXP_W];
    assign ey     = y_r[MAN_W +: EXP_W];
    assign sign_d = x_r[31] ^ y_r[31];

    fdiv_seed_rom #(.SEED_BITS(SEED_BITS)) u_seed_rom (
        .idx  (y_r[MAN_W-1 -: SEED_BITS]),
        .seed (seed)
    );

    // Single shared multiplier. Fixed-point views: ym/xm as Q1.31, xk as Q0.32,
    // (2-b) as Q1.31, so every product is scaled by 2^-63.
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] prod;
    logic [31:0] two_minus_b;
    logic [31:0] x_next;

    assign two_minus_b = ~b_r + 32'd1;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            IT1A, IT2A: begin mul_a = {ym, 8'h0};  mul_b = xk;          end
            IT1B, IT2B: begin mul_a = xk;          mul_b = two_minus_b; end
            MUL:        begin mul_a = {xm, 8'h0};  mul_b = xk;          end
            FIX:        begin mul_a = {6'h0, q_r}; mul_b = {8'h0, ym};  end
            default:    ;
        endcase
    end

    assign prod = {32'h0, mul_a} * {32'h0, mul_b};

    // Truncating b can push x(2-b) a hair past 1.0 when ym is 1.0; saturate.
    assign x_next = prod[63] ? 32'hFFFF_FFFF : prod[62:31];

    // Exact remainder at the 25-bit quotient scale (24 mantissa bits + guard).
    logic [63:0] num_fix;
    logic [63:0] rem;
    logic [63:0] rem_fix;
    logic [25:0] q_fix;
    logic        rem_neg;
    logic        rem_hi;

    assign num_fix = lt_r ? {15'h0, xm, 25'h0} : {16'h0, xm, 24'h0};
    assign rem     = num_fix - prod;
    assign rem_neg = rem[63];
    assign rem_hi  = !rem_neg && (rem >= {40'h0, ym});
    assign q_fix   = rem_neg ? q_r - 26'd1 : (rem_hi ? q_r + 26'd1 : q_r);
    assign rem_fix = rem_neg ? rem + {40'h0, ym} : (rem_hi ? rem - {40'h0, ym} : rem);

    // Round to nearest even, then pack with exponent range and special operands.
    logic               round_up;
    logic [24:0]        m_rnd;
    logic signed [10:0] e_rnd;
    logic [31:0]        d_nxt;
    logic               ovf_nxt;
    logic               unf_nxt;
    logic               unused_mant_msb;

    assign round_up        = q_r[0] & (sticky | q_r[1]);
    assign m_rnd           = {1'b0, q_r[24:1]} + {24'h0, round_up};
    assign unused_mant_msb = m_rnd[23];
    assign e_rnd = $signed({3'h0, ex}) - $signed({3'h0, ey}) + $signed(11'(BIAS))
                 - $signed({10'h0, lt_r}) + $signed({10'h0, m_rnd[24]});

    always_comb begin
        d_nxt   = {sign_d, ZERO_MAG};
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (ey == '0) begin
            d_nxt   = {sign_d, INF_MAG};
            ovf_nxt = 1'b1;
        end else if (ex == '0 || ey == '1) begin
            d_nxt = {sign_d, ZERO_MAG};
        end else if (ex == '1 || e_rnd >= 11'sd255) begin
            d_nxt   = {sign_d, INF_MAG};
            ovf_nxt = 1'b1;
        end else if (e_rnd <= 11'sd0) begin
            unf_nxt = 1'b1;
        end else begin
            d_nxt = {sign_d, e_rnd[7:0], m_rnd[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.d         <= '0;
            io.overflow  <= 1'b0;
            io.underflow <= 1'b0;
            x_r          <= '0;
            y_r          <= '0;
            xk           <= '0;
            b_r          <= '0;
            q_r          <= '0;
            sticky       <= 1'b0;
            lt_r         <= 1'b0;
            it_cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    x_r         <= io.x;
                    y_r         <= io.y;
                    io.in_ready <= 1'b0;
                    state       <= SEED;
                end
                SEED: begin
                    xk     <= {1'b1, seed, {(31-SEED_BITS){1'b0}}};
                    lt_r   <= (xm < ym);
                    it_cnt <= '0;
                    state  <= IT1A;
                end
                IT1A: begin
                    b_r   <= prod[63:32];
                    state <= IT1B;
                end
                IT1B: begin
                    xk    <= x_next;
                    state <= (NEWTON_ITERS > 1) ? IT2A : MUL;
                end
                IT2A: begin
                    b_r   <= prod[63:32];
                    state <= IT2B;
                end
                // Iterations beyond the second reuse the IT2 pair.
                IT2B: begin
                    xk     <= x_next;
                    it_cnt <= it_cnt + 3'd1;
                    state  <= (int'(it_cnt) + 2 < NEWTON_ITERS) ? IT2A : MUL;
                end
                MUL: begin
                    q_r   <= lt_r ? prod[63:38] : {1'b0, prod[63:39]};
                    state <= FIX;
                end
                FIX: begin
                    q_r    <= q_fix;
                    sticky <= |rem_fix;
                    state  <= RND;
                end
                RND: begin
                    io.d         <= d_nxt;
                    io.overflow  <= ovf_nxt;
                    io.underflow <= unf_nxt;
                    io.out_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (io.out_ready) begin
                    io.out_valid <= 1'b0;
                    io.in_ready  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
